// File: rtl/ram_rd_streamer_pkg.sv
// Shared accelerator definitions for the RAM read streamer: default geometry
// and the controller state encoding.
package ram_rd_streamer_pkg;

    localparam int PKG_VEC_WIDTH = 264;
    localparam int PKG_ARR_DEPTH = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stream_state_e;

endpackage

// File: rtl/vec_fifo2.sv
// Two-entry vector FIFO with registered head outputs; push and pop may
// happen in the same cycle.
module vec_fifo2
    import ram_rd_streamer_pkg::*;
#(
    parameter int VEC_WIDTH = PKG_VEC_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic [VEC_WIDTH-1:0] i_push_data,
    input  logic                 i_push_last,
    input  logic                 i_pop,
    output logic                 o_valid,
    output logic [VEC_WIDTH-1:0] o_data,
    output logic                 o_last,
    output logic [1:0]           o_count
);

    logic [VEC_WIDTH-1:0] head_data_r;
    logic                 head_last_r;
    logic [VEC_WIDTH-1:0] tail_data_r;
    logic                 tail_last_r;
    logic [1:0]           count_r;
    logic                 do_pop_s;

    // Pop qualifier: an empty FIFO never pops
    always_comb begin
        do_pop_s = 1'b0;
        if (i_pop && (count_r != 2'd0)) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
    end

    // Head/tail storage and occupancy; the head register drives the outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_data_r <= '0;
            head_last_r <= 1'b0;
            tail_data_r <= '0;
            tail_last_r <= 1'b0;
            count_r     <= 2'd0;
        end else begin
            case ({i_push, do_pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_data_r <= i_push_data;
                        head_last_r <= i_push_last;
                        count_r     <= 2'd1;
                    end else if (count_r == 2'd1) begin
                        tail_data_r <= i_push_data;
                        tail_last_r <= i_push_last;
                        count_r     <= 2'd2;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_data_r <= tail_data_r;
                        head_last_r <= tail_last_r;
                    end else begin
                        head_last_r <= 1'b0;
                    end
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; new data lands behind whatever remains
                    if (count_r == 2'd1) begin
                        head_data_r <= i_push_data;
                        head_last_r <= i_push_last;
                    end else begin
                        head_data_r <= tail_data_r;
                        head_last_r <= tail_last_r;
                        tail_data_r <= i_push_data;
                        tail_last_r <= i_push_last;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign o_valid = (count_r != 2'd0);
    assign o_data  = head_data_r;
    assign o_last  = head_last_r && (count_r != 2'd0);
    assign o_count = count_r;

endmodule

// File: rtl/ram_rd_streamer.sv
// Streams a run of vectors out of a synchronous RAM onto a valid/ready bus,
// issuing reads only when the output FIFO is guaranteed to have room.
module ram_rd_streamer
    import ram_rd_streamer_pkg::*;
#(
    parameter int VEC_WIDTH  = PKG_VEC_WIDTH,
    parameter int ARR_DEPTH  = PKG_ARR_DEPTH,
    parameter int ADDR_WIDTH = $clog2(ARR_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [VEC_WIDTH-1:0]  i_ram_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [VEC_WIDTH-1:0]  o_data,
    output logic                  o_last
);

    localparam int LEN_WIDTH = ADDR_WIDTH + 1;

    stream_state_e         state_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [LEN_WIDTH-1:0]  remaining_r;
    logic                  prime_r;
    logic                  inflight_r;
    logic                  last_inflight_r;
    logic                  busy_r;
    logic                  done_r;

    logic [1:0]            fifo_count_s;
    logic                  fifo_valid_s;
    logic                  fifo_last_s;
    logic                  pop_s;
    logic [2:0]            occupancy_s;
    logic                  credit_ok_s;
    logic                  last_read_s;
    logic                  issue_s;

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] addr);
        if (addr == ADDR_WIDTH'(ARR_DEPTH - 1)) begin
            return '0;
        end else begin
            return addr + ADDR_WIDTH'(1);
        end
    endfunction

    // Read-credit decision: FIFO entries plus the read in flight, minus this cycle's pop
    always_comb begin
        pop_s       = fifo_valid_s && i_ready;
        occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_r};
        credit_ok_s = occupancy_s < (3'd2 + {2'b00, pop_s});
        last_read_s = (remaining_r == LEN_WIDTH'(1));
        issue_s     = 1'b0;
        if ((state_r == RUN) && !prime_r && (remaining_r != '0)) begin
            issue_s = credit_ok_s;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Controller: command acceptance, read issue, completion and busy/done flags.
    // The first RUN cycle only lets the base address settle at the RAM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r         <= IDLE;
            ram_addr_r      <= '0;
            remaining_r     <= '0;
            prime_r         <= 1'b0;
            inflight_r      <= 1'b0;
            last_inflight_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            done_r          <= 1'b0;
            inflight_r      <= issue_s;
            last_inflight_r <= issue_s && last_read_s;
            case (state_r)
                IDLE: begin
                    if (done_r) begin
                        busy_r <= 1'b0;
                    end else if (i_start) begin
                        busy_r <= 1'b1;
                        if (i_len == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r     <= RUN;
                            ram_addr_r  <= i_base_addr;
                            remaining_r <= i_len;
                            prime_r     <= 1'b1;
                        end
                    end else begin
                        busy_r <= busy_r;
                    end
                end
                RUN: begin
                    prime_r <= 1'b0;
                    if (issue_s) begin
                        ram_addr_r  <= addr_inc(ram_addr_r);
                        remaining_r <= remaining_r - LEN_WIDTH'(1);
                        if (last_read_s) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                DRAIN: begin
                    if (pop_s && fifo_last_s) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    vec_fifo2 #(
        .VEC_WIDTH (VEC_WIDTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (inflight_r),
        .i_push_data (i_ram_data),
        .i_push_last (last_inflight_r),
        .i_pop       (pop_s),
        .o_valid     (fifo_valid_s),
        .o_data      (o_data),
        .o_last      (fifo_last_s),
        .o_count     (fifo_count_s)
    );

    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_ram_we   = 1'b0;
    assign o_ram_addr = ram_addr_r;
    assign o_valid    = fifo_valid_s;
    assign o_last     = fifo_last_s;

endmodule

// File: doc/ram_rd_streamer.md
RAM_RD_STREAMER -- requirements
Module: ram_rd_streamer

Interface
REQ-001 SHALL have parameter VEC_WIDTH, default 264, vector width in bits.
REQ-002 SHALL have parameter ARR_DEPTH, default 2048, number of RAM entries.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(ARR_DEPTH), RAM address width.
REQ-004 SHALL have port i_clk, input, 1, clock; all logic on the rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_start, input, 1, one-cycle command strobe.
REQ-007 SHALL have port i_base_addr, input, ADDR_WIDTH, first RAM address, sampled with i_start.
REQ-008 SHALL have port i_len, input, ADDR_WIDTH+1, vector count 0..ARR_DEPTH, sampled with i_start.
REQ-009 SHALL have port o_busy, output, 1, high from the cycle after an accepted start until the done cycle, inclusive.
REQ-010 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port o_ram_we, output, 1, RAM write enable, constant 0.
REQ-012 SHALL have port o_ram_addr, output, ADDR_WIDTH, RAM address (registered).
REQ-013 SHALL have port i_ram_data, input, VEC_WIDTH, RAM read data, valid one cycle after its address is presented.
REQ-014 SHALL have ports o_valid (output, 1), i_ready (input, 1), o_data (output, VEC_WIDTH) and o_last (output, 1), forming the downstream stream; o_last marks the final vector.

Function
REQ-015 SHALL use FSM states IDLE, RUN and DRAIN.
- IDLE->RUN: i_start && i_len!=0.
- RUN->DRAIN: the last read has been issued.
- DRAIN->IDLE: handshake on the final vector.
REQ-016 SHALL ignore i_start while o_busy=1.
REQ-017 SHALL, when i_start is sampled with i_len=0, pulse o_done on the next cycle, issue no reads and assert no o_valid.
REQ-018 SHALL issue reads at addresses base, base+1, ..., with the address wrapping from ARR_DEPTH-1 to 0.
REQ-019 SHALL count a read as issued in a RUN cycle that satisfies the credit rule; each issued read's i_ram_data SHALL be captured in the following cycle.
REQ-020 SHALL buffer captured data in an internal 2-entry FIFO that drives o_data and o_valid (o_valid = FIFO not empty).
REQ-021 SHALL issue a read only if (fifo_count + inflight - pop) < 2.
- pop = o_valid && i_ready.
- This rule guarantees no FIFO overflow and no data loss under arbitrary i_ready.
REQ-022 SHALL provide a first-vector latency of 3 cycles: start sampled at edge E0 gives o_valid=1 after edge E3.
REQ-023 SHALL sustain 1 vector/cycle while i_ready=1.
REQ-024 SHALL hold o_data, o_valid and o_last stable while o_valid && !i_ready.
REQ-025 SHALL assert o_last together with o_valid on the i_len-th vector only.
REQ-026 SHALL pulse o_done in the cycle after the final handshake; o_busy SHALL fall in the following cycle.
REQ-027 SHALL support simultaneous push and pop on the FIFO with count unchanged.
REQ-028 SHALL accept i_len=ARR_DEPTH, reading every entry once with full wrap.

Reset
REQ-029 SHALL on reset assertion immediately force:
- state=IDLE;
- o_ram_addr=0, o_ram_we=0;
- FIFO empty, inflight=0;
- o_valid=0, o_last=0, o_data=0;
- o_busy=0, o_done=0.
REQ-030 SHALL, on reset mid-transfer, discard all pending data; the first post-reset start SHALL behave as from power-up.

Structure
REQ-031 SHALL take VEC_WIDTH, ARR_DEPTH and the FSM state encoding from the shared accelerator package.
REQ-032 SHALL place the 2-entry FIFO in a sub-module named vec_fifo2, parameterized by VEC_WIDTH.

Verification
REQ-033 SHALL cover: base=5, len=4, i_ready=1, RAM[5..8]=A..D -> A,B,C,D on consecutive cycles; o_last with D; one o_done.
REQ-034 SHALL cover: base=2046, len=4 -> addresses 2046, 2047, 0, 1 in order.
REQ-035 SHALL cover: len=6 with i_ready toggling 1,0,0,1,0,1... -> all 6 vectors in order, none dropped or duplicated, output stable while stalled.
REQ-036 SHALL cover: len=0 -> o_done pulse 1 cycle after start, no o_valid.
REQ-037 SHALL cover: i_start pulsed again mid-transfer with different base -> ignored, first transfer completes unchanged.
REQ-038 SHALL cover: reset asserted after 2 of 8 vectors -> outputs 0 immediately; new transfer base=0, len=2 completes correctly.
